// File: rtl/instruction_control_pkg.sv
// instruction_control_pkg: opcodes, FSM state codes and accumulator source selects
// shared by the instruction sequencer and its decoder.
package instruction_control_pkg;

    localparam logic [4:0] OP_HLT  = 5'd0;
    localparam logic [4:0] OP_STO  = 5'd1;
    localparam logic [4:0] OP_LD   = 5'd2;
    localparam logic [4:0] OP_LDI  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SUBI = 5'd7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [1:0] SEL_MEM = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    function automatic logic uses_alu(input logic [4:0] op);
        return op >= OP_ADD && op <= OP_SUBI;
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// instruction_decoder: maps an opcode to memory strobes and accumulator-path controls,
// gated by the FSM phase in which each control is meaningful.
module instruction_decoder
    import instruction_control_pkg::*;
(
    input  logic [4:0] op_i,
    input  logic       decode_i,
    input  logic       exec_i,
    output logic       data_rd_o,
    output logic       data_wr_o,
    output logic [1:0] sel_a_o,
    output logic       sel_b_o,
    output logic       alu_sub_o,
    output logic       acc_wr_o
);

    always_comb begin
        data_rd_o = decode_i && (op_i == OP_LD || op_i == OP_ADD || op_i == OP_SUB);
        data_wr_o = decode_i && op_i == OP_STO;
        // Opcodes at or above 01000 fall outside LD..SUBI and so behave as NOPs.
        acc_wr_o  = exec_i && op_i >= OP_LD && op_i <= OP_SUBI;
        sel_a_o   = !exec_i ? SEL_MEM : op_i == OP_LDI ? SEL_IMM : uses_alu(op_i) ? SEL_ALU : SEL_MEM;
        sel_b_o   = exec_i && (op_i == OP_ADDI || op_i == OP_SUBI);
        alu_sub_o = exec_i && (op_i == OP_SUB || op_i == OP_SUBI);
    end

endmodule

// File: rtl/instruction_control.sv
// instruction_control: fetch/decode/execute sequencer for the accumulator CPU; owns the
// PC, instruction register and active-cycle counter, drives program and data memory.
module instruction_control
    import instruction_control_pkg::*;
#(
    parameter int ADDR_LENGTH = 11,
    parameter int DATA_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] instruction,
    output logic [ADDR_LENGTH-1:0] pc,
    output logic                   prog_wr,
    output logic [ADDR_LENGTH-1:0] data_addr,
    output logic                   data_rd,
    output logic                   data_wr,
    output logic [DATA_LENGTH-1:0] imm,
    output logic [1:0]             sel_a,
    output logic                   sel_b,
    output logic                   alu_sub,
    output logic                   acc_wr,
    output logic                   halted,
    output logic [15:0]            cycle_count
);

    logic [2:0]             state_q, state_d;
    logic [ADDR_LENGTH-1:0] pc_q, pc_d;
    logic [DATA_LENGTH-1:0] ir_q, ir_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0] cur;
    logic                   in_decode, in_exec, active;

    // Fields come straight from memory during DECODE so the strobes land in that cycle.
    assign in_decode = state_q == ST_DECODE;
    assign in_exec   = state_q == ST_EXEC;
    assign active    = state_q == ST_FETCH || in_decode || in_exec;
    assign cur       = in_decode ? instruction : ir_q;

    always_comb begin
        state_d = state_q == ST_IDLE   ? (start ? ST_FETCH : ST_IDLE) :
                  state_q == ST_FETCH  ? ST_DECODE :
                  in_decode            ? (instruction[DATA_LENGTH-1 -: 5] == OP_HLT ? ST_HALT : ST_EXEC) :
                  in_exec              ? ST_FETCH : ST_HALT;
        pc_d    = in_exec ? pc_q + 1'b1 : pc_q;
        ir_d    = in_decode ? instruction : ir_q;
        cnt_d   = active && cnt_q != 16'hFFFF ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    instruction_decoder u_dec (
        .op_i      (cur[DATA_LENGTH-1 -: 5]),
        .decode_i  (in_decode),
        .exec_i    (in_exec),
        .data_rd_o (data_rd),
        .data_wr_o (data_wr),
        .sel_a_o   (sel_a),
        .sel_b_o   (sel_b),
        .alu_sub_o (alu_sub),
        .acc_wr_o  (acc_wr)
    );

    assign pc          = pc_q;
    assign prog_wr     = 1'b0;
    assign data_addr   = cur[ADDR_LENGTH-1:0];
    assign imm         = {{(DATA_LENGTH-11){cur[10]}}, cur[10:0]};
    assign halted      = state_q == ST_HALT;
    assign cycle_count = cnt_q;

endmodule
